pe_mem_acc_dma_port: RTL

//  Memory-side responder for the PE DMA<->memory port. Sits directly downstream of the PE DMA engine.

---
 rtl/pe_mem_acc_dma_port.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pe_mem_acc_dma_port.sv
// Memory-side DMA port: arbitrates DMA reads/writes onto one single-port SRAM bank
// and returns read words in accept order through a credit-protected output FIFO.
module pe_mem_acc_dma_port #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 128,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dma__memc__write_valid,
    input  logic [ADDR_WIDTH-1:0] dma__memc__write_address,
    input  logic [DATA_WIDTH-1:0] dma__memc__write_data,
    output logic                  memc__dma__write_ready,
    input  logic                  dma__memc__read_valid,
    input  logic [ADDR_WIDTH-1:0] dma__memc__read_address,
    output logic                  memc__dma__read_ready,
    output logic [DATA_WIDTH-1:0] memc__dma__read_data,
    output logic                  memc__dma__read_data_valid,
    input  logic                  dma__memc__read_pause,
    output logic                  memc__sram__en,
    output logic                  memc__sram__we,
    output logic [ADDR_WIDTH-1:0] memc__sram__addr,
    output logic [DATA_WIDTH-1:0] memc__sram__wdata,
    input  logic [DATA_WIDTH-1:0] sram__memc__rdata
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CRD_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {SIDE_WRITE = 1'b0, SIDE_READ = 1'b1} side_t;

    side_t                 r_rr_last;
    logic [CRD_W-1:0]      r_credit;
    logic [RD_LATENCY:0]   r_rd_pipe;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_fifo_mem [FIFO_DEPTH];

    logic w_rd_eligible;
    logic w_conflict;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_full;

    assign w_rd_eligible = dma__memc__read_valid && (r_credit != '0);
    assign w_conflict    = dma__memc__write_valid && w_rd_eligible;

    // Round-robin only matters on a conflict; the side that lost last time wins.
    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (w_conflict) begin
            if (r_rr_last == SIDE_READ) w_grant_wr = 1'b1;
            else                        w_grant_rd = 1'b1;
        end else if (dma__memc__write_valid) begin
            w_grant_wr = 1'b1;
        end else if (w_rd_eligible) begin
            w_grant_rd = 1'b1;
        end
    end

    assign memc__dma__write_ready = w_grant_wr;
    assign memc__dma__read_ready  = w_grant_rd;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    assign w_push  = r_rd_pipe[RD_LATENCY];
    assign w_pop   = !dma__memc__read_pause && !w_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_last         <= SIDE_READ;
            memc__sram__en    <= 1'b0;
            memc__sram__we    <= 1'b0;
            memc__sram__addr  <= '0;
            memc__sram__wdata <= '0;
        end else begin
            if (w_conflict) r_rr_last <= w_grant_wr ? SIDE_WRITE : SIDE_READ;
            memc__sram__en <= w_grant_wr || w_grant_rd;
            if (w_grant_wr) begin
                memc__sram__we    <= 1'b1;
                memc__sram__addr  <= dma__memc__write_address;
                memc__sram__wdata <= dma__memc__write_data;
            end else if (w_grant_rd) begin
                memc__sram__we   <= 1'b0;
                memc__sram__addr <= dma__memc__read_address;
            end
        end
    end

    // Tracks which cycles carry a read word out of the SRAM; cleared on reset so
    // reads in flight at reset never reach the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe <= {r_rd_pipe[RD_LATENCY-1:0], w_grant_rd};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credit <= CRD_W'(FIFO_DEPTH);
        end else if (w_grant_rd && !w_pop) begin
            r_credit <= r_credit - CRD_W'(1);
        end else if (!w_grant_rd && w_pop) begin
            r_credit <= r_credit + CRD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr[IDX_W-1:0]] <= sram__memc__rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr                   <= '0;
            r_rd_ptr                   <= '0;
            memc__dma__read_data       <= '0;
            memc__dma__read_data_valid <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) begin
                r_rd_ptr                   <= r_rd_ptr + PTR_W'(1);
                memc__dma__read_data       <= r_fifo_mem[r_rd_ptr[IDX_W-1:0]];
                memc__dma__read_data_valid <= 1'b1;
            end else begin
                memc__dma__read_data_valid <= 1'b0;
            end
        end
    end

    // Credits bound FIFO occupancy plus reads in flight, so a push never meets a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(w_push && w_full));

endmodule
